// File: rtl/mm_job_arbiter.sv
// Round-robin arbiter that lends one matrix-multiplier engine to NUM_REQ requesters, one whole job at a time.
// Optional compute watchdog: define MM_ARB_WDOG_EN to abort jobs whose engine stays busy for WDOG_CYCLES cycles.
module mm_job_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_col_end,
    input  logic [NUM_REQ-1:0]            req_row_end,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [DATA_WIDTH-1:0]         mm_in_data,
    output logic                          mm_col_end,
    output logic                          mm_row_end,
    input  logic                          mm_busy,
    input  logic                          mm_valid,
    input  logic                          mm_is_legal,
    input  logic [19:0]                   mm_out_data,
    output logic [NUM_REQ-1:0]            res_valid,
    output logic [19:0]                   res_data,
    output logic [NUM_REQ-1:0]            res_illegal,
    output logic [NUM_REQ-1:0]            job_done,
    output logic [NUM_REQ-1:0]            job_err,
    output logic [1:0]                    dbg_state
);

    localparam int OW = (NUM_REQ > 2) ? 2 : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]         state;
    logic [OW-1:0]      owner;
    logic [OW-1:0]      rr_ptr;
    logic [OW-1:0]      winner;
    logic [OW-1:0]      scan_idx;
    logic               any_req;
    logic               rowend_cnt;
    logic               wdog_hit;
    logic [NUM_REQ-1:0] owner_onehot;
    logic [NUM_REQ-1:0] winner_onehot;

    // Scan downwards so the last hit, which is the first in rr_ptr+1.. order, wins.
    always_comb begin
        winner   = rr_ptr;
        any_req  = 1'b0;
        scan_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            scan_idx = OW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[scan_idx]) begin
                winner  = scan_idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        owner_onehot          = '0;
        owner_onehot[owner]   = 1'b1;
        winner_onehot         = '0;
        winner_onehot[winner] = 1'b1;
    end

    // Only the owner's stream reaches the engine, and only while loading.
    always_comb begin
        mm_in_data = '0;
        mm_col_end = 1'b0;
        mm_row_end = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (state == S_LOAD && owner == OW'(k)) begin
                mm_in_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
                mm_col_end = req_col_end[k];
                mm_row_end = req_row_end[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            gnt        <= '0;
            owner      <= '0;
            rr_ptr     <= OW'(NUM_REQ - 1);
            rowend_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        gnt   <= winner_onehot;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // First row_end closes A, second closes B and hands off to the engine.
                    if (mm_row_end) begin
                        if (rowend_cnt) begin
                            rowend_cnt <= 1'b0;
                            state      <= S_COMPUTE;
                        end else begin
                            rowend_cnt <= 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (!mm_busy || wdog_hit) begin
                        state <= S_RELEASE;
                    end
                end
                default: begin
                    gnt    <= '0;
                    rr_ptr <= owner;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MM_ARB_WDOG_EN
    logic [15:0] wdog_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state == S_LOAD && mm_row_end && rowend_cnt) begin
            wdog_cnt <= '0;
        end else if (state == S_COMPUTE) begin
            wdog_cnt <= wdog_cnt + 16'd1;
        end
    end

    assign wdog_hit = (state == S_COMPUTE) && mm_busy && (wdog_cnt == 16'(WDOG_CYCLES - 1));
    assign job_err  = wdog_hit ? owner_onehot : '0;
`else
    assign wdog_hit = 1'b0;
    assign job_err  = '0;
`endif

    // Result path has no back-pressure: res_valid is a one-cycle strobe qualified by
    // mm_valid & mm_is_legal, and the owner must take res_data in the cycle it is high.
    assign res_data    = mm_out_data;
    assign res_valid   = (state == S_COMPUTE && mm_valid && mm_is_legal)  ? owner_onehot : '0;
    assign res_illegal = (state == S_COMPUTE && mm_valid && !mm_is_legal) ? owner_onehot : '0;
    assign job_done    = (state == S_RELEASE) ? owner_onehot : '0;
    assign dbg_state   = state;

endmodule
